// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one memory port between instruction fetch (IF) and data access
//   (MEM). Only one transaction is outstanding at a time, and data always wins
//   a grant. Back-to-back grants are loaded on the ack edge, so the port
//   never sits idle between transactions.
//
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   ireq/iaddr/iflush IF request, fetch address, result-not-wanted strobe
//   instr/iready      fetched word and its one-cycle completion pulse
//   dreq/dwe/daddr/dwdata  MEM request, store flag, address, store data
//   drdata/dready     load data and its one-cycle completion pulse
//   stall_if/stall_mem  combinational per-stage stalls
//   mem_req/mem_we/mem_addr/mem_wdata  registered memory command
//   mem_ack/mem_rdata memory completion and read data
//   contention_cnt    saturating count of cycles IF was held off by data
//
// state | meaning
// IDLE  | no transaction outstanding, mem_req=0
// IBUSY | fetch outstanding at memory
// DBUSY | load/store outstanding at memory

module mem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ireq,
    input  logic [AW-1:0] iaddr,
    input  logic          iflush,
    output logic [DW-1:0] instr,
    output logic          iready,
    input  logic          dreq,
    input  logic          dwe,
    input  logic [AW-1:0] daddr,
    input  logic [DW-1:0] dwdata,
    output logic [DW-1:0] drdata,
    output logic          dready,
    output logic          stall_if,
    output logic          stall_mem,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic [CW-1:0] contention_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic          drop, drop_nxt;
    logic          mem_req_nxt, mem_we_nxt;
    logic [AW-1:0] mem_addr_nxt;
    logic [DW-1:0] mem_wdata_nxt;
    logic [DW-1:0] instr_nxt, drdata_nxt;
    logic          iready_nxt, dready_nxt;
    logic [CW-1:0] cnt_nxt;

    logic ack;
    logic grant_pt;
    logic d_elig;
    logic i_elig;

    assign stall_if  = ireq & ~iready;
    assign stall_mem = dreq & ~dready;

    // An ack only counts while a transaction is actually outstanding.
    assign ack      = mem_req & mem_ack;
    assign grant_pt = (state == IDLE) | ack;

    // The port completing on this edge is not eligible: its ready pulse has
    // not risen yet but its request is already being served. Without this,
    // a held request would be re-issued on its own ack edge.
    assign d_elig = dreq & ~dready & ~((state == DBUSY) & ack);
    assign i_elig = ireq & ~iready & ~((state == IBUSY) & ack);

    always_comb begin
        state_nxt     = state;
        drop_nxt      = drop;
        mem_req_nxt   = mem_req;
        mem_we_nxt    = mem_we;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        instr_nxt     = instr;
        drdata_nxt    = drdata;
        iready_nxt    = 1'b0;
        dready_nxt    = 1'b0;
        cnt_nxt       = contention_cnt;

        if (i_elig && ((state == DBUSY) || (grant_pt && d_elig)) &&
            (contention_cnt != {CW{1'b1}})) begin
            cnt_nxt = contention_cnt + 1'b1;
        end

        if ((state == IBUSY) && iflush) begin
            drop_nxt = 1'b1;
        end

        if (ack) begin
            if (state == DBUSY) begin
                dready_nxt = 1'b1;
                if (!mem_we) begin
                    drdata_nxt = mem_rdata;
                end
            end else if (state == IBUSY) begin
                // A flush seen in the ack cycle itself also suppresses delivery.
                if (!(drop || iflush)) begin
                    instr_nxt  = mem_rdata;
                    iready_nxt = 1'b1;
                end
            end
        end

        if (grant_pt) begin
            if (d_elig) begin
                state_nxt     = DBUSY;
                mem_req_nxt   = 1'b1;
                mem_we_nxt    = dwe;
                mem_addr_nxt  = daddr;
                mem_wdata_nxt = dwdata;
            end else if (i_elig && !iflush) begin
                state_nxt    = IBUSY;
                mem_req_nxt  = 1'b1;
                mem_we_nxt   = 1'b0;
                mem_addr_nxt = iaddr;
                drop_nxt     = 1'b0;
            end else begin
                state_nxt   = IDLE;
                mem_req_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            drop           <= 1'b0;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            instr          <= '0;
            drdata         <= '0;
            iready         <= 1'b0;
            dready         <= 1'b0;
            contention_cnt <= '0;
        end else begin
            state          <= state_nxt;
            drop           <= drop_nxt;
            mem_req        <= mem_req_nxt;
            mem_we         <= mem_we_nxt;
            mem_addr       <= mem_addr_nxt;
            mem_wdata      <= mem_wdata_nxt;
            instr          <= instr_nxt;
            drdata         <= drdata_nxt;
            iready         <= iready_nxt;
            dready         <= dready_nxt;
            contention_cnt <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed scenarios followed by randomized traffic for mem_arbiter,
//   compared every cycle against a transaction-level reference model.

module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = 4;

    localparam int NONE  = 0;
    localparam int FETCH = 1;
    localparam int DATA  = 2;

    logic          clk;
    logic          reset;
    logic          ireq;
    logic [AW-1:0] iaddr;
    logic          iflush;
    logic [DW-1:0] instr;
    logic          iready;
    logic          dreq;
    logic          dwe;
    logic [AW-1:0] daddr;
    logic [DW-1:0] dwdata;
    logic [DW-1:0] drdata;
    logic          dready;
    logic          stall_if;
    logic          stall_mem;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic [CW-1:0] contention_cnt;

    int n_total;
    int n_pass;

    // reference model: who owns the memory port and what it promised
    int          m_owner;
    bit          m_req;
    bit          m_we;
    bit          m_iready;
    bit          m_dready;
    bit          m_drop;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_instr;
    logic [31:0] m_drdata;
    int          m_cnt;

    mem_arbiter #(.AW(AW), .DW(DW), .CW(CW)) dut (
        .clk            (clk),
        .reset          (reset),
        .ireq           (ireq),
        .iaddr          (iaddr),
        .iflush         (iflush),
        .instr          (instr),
        .iready         (iready),
        .dreq           (dreq),
        .dwe            (dwe),
        .daddr          (daddr),
        .dwdata         (dwdata),
        .drdata         (drdata),
        .dready         (dready),
        .stall_if       (stall_if),
        .stall_mem      (stall_mem),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .contention_cnt (contention_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_reset();
        m_owner  = NONE;
        m_req    = 0;
        m_we     = 0;
        m_iready = 0;
        m_dready = 0;
        m_drop   = 0;
        m_addr   = '0;
        m_wdata  = '0;
        m_instr  = '0;
        m_drdata = '0;
        m_cnt    = 0;
    endtask

    // One clock edge of the arbitration rules, using the inputs present
    // before the edge and the model's own view of the outputs.
    task automatic model_step();
        bit ack;
        bit can_grant;
        bit d_wants;
        bit i_wants;
        ack       = m_req && (mem_ack === 1'b1);
        can_grant = (m_owner == NONE) || ack;
        d_wants   = dreq && !m_dready && !(m_owner == DATA && ack);
        i_wants   = ireq && !m_iready && !(m_owner == FETCH && ack);

        if (i_wants && (m_owner == DATA || (can_grant && d_wants)) && m_cnt < (1 << CW) - 1)
            m_cnt++;

        m_iready = 0;
        m_dready = 0;
        if (m_owner == FETCH && iflush) m_drop = 1;

        if (ack && m_owner == DATA) begin
            m_dready = 1;
            if (!m_we) m_drdata = mem_rdata;
        end
        if (ack && m_owner == FETCH && !m_drop) begin
            m_iready = 1;
            m_instr  = mem_rdata;
        end

        if (can_grant) begin
            if (d_wants) begin
                m_owner = DATA;
                m_req   = 1;
                m_we    = dwe;
                m_addr  = daddr;
                m_wdata = dwdata;
            end else if (i_wants && !iflush) begin
                m_owner = FETCH;
                m_req   = 1;
                m_we    = 0;
                m_addr  = iaddr;
                m_drop  = 0;
            end else begin
                m_owner = NONE;
                m_req   = 0;
            end
        end
    endtask

    task automatic compare_all();
        chk("mem_req", 32'(mem_req), 32'(m_req));
        if (m_req) begin
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_we", 32'(mem_we), 32'(m_we));
            if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
        end
        chk("iready", 32'(iready), 32'(m_iready));
        chk("dready", 32'(dready), 32'(m_dready));
        chk("instr", instr, m_instr);
        chk("drdata", drdata, m_drdata);
        chk("contention_cnt", 32'(contention_cnt), 32'(m_cnt));
        chk("stall_if", 32'(stall_if), 32'(ireq & ~m_iready));
        chk("stall_mem", 32'(stall_mem), 32'(dreq & ~m_dready));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    // Called just after a sample point; reset lands between clock edges.
    task automatic do_reset();
        #2 reset = 1'b1;
        model_reset();
        #1;
        compare_all();
        chk("rst_mem_addr", mem_addr, 32'h0);
        #2 reset = 1'b0;
    endtask

    initial begin
        n_total   = 0;
        n_pass    = 0;
        reset     = 1'b1;
        ireq      = 1'b0;
        iaddr     = '0;
        iflush    = 1'b0;
        dreq      = 1'b0;
        dwe       = 1'b0;
        daddr     = '0;
        dwdata    = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        #2 reset = 1'b0;

        // lone fetch, ack on the second cycle of mem_req
        ireq = 1'b1; iaddr = 32'h40;
        cycle();
        chk("lone_addr", mem_addr, 32'h40);
        chk("lone_stall", 32'(stall_if), 32'h1);
        cycle();
        mem_ack = 1'b1; mem_rdata = 32'h2402000A;
        cycle();
        chk("lone_iready", 32'(iready), 32'h1);
        chk("lone_instr", instr, 32'h2402000A);
        mem_ack = 1'b0;
        cycle();
        chk("lone_no_reissue", 32'(mem_req), 32'h0);
        chk("lone_pulse", 32'(iready), 32'h0);
        ireq = 1'b0;
        cycle();

        // simultaneous fetch and load, immediate acks
        ireq = 1'b1; iaddr = 32'h44;
        dreq = 1'b1; dwe = 1'b0; daddr = 32'h100;
        mem_ack = 1'b1; mem_rdata = 32'h11111111;
        cycle();
        chk("sim_data_first", mem_addr, 32'h100);
        cycle();
        chk("sim_dready", 32'(dready), 32'h1);
        chk("sim_fetch_b2b", 32'(mem_req), 32'h1);
        chk("sim_fetch_addr", mem_addr, 32'h44);
        chk("sim_contention", 32'(contention_cnt), 32'h2);
        dreq = 1'b0; mem_rdata = 32'h22222222;
        cycle();
        chk("sim_instr", instr, 32'h22222222);
        ireq = 1'b0; mem_ack = 1'b0;
        cycle();

        // store leaves drdata alone
        dreq = 1'b1; dwe = 1'b1; daddr = 32'h200; dwdata = 32'hDEADBEEF;
        cycle();
        chk("st_we", 32'(mem_we), 32'h1);
        chk("st_wdata", mem_wdata, 32'hDEADBEEF);
        mem_ack = 1'b1; mem_rdata = 32'h55555555;
        cycle();
        chk("st_dready", 32'(dready), 32'h1);
        chk("st_drdata", drdata, 32'h11111111);
        dreq = 1'b0; dwe = 1'b0; mem_ack = 1'b0;
        cycle();

        // flush inside a three-cycle fetch, then refetch at 0x80
        ireq = 1'b1; iaddr = 32'h60;
        cycle();
        iflush = 1'b1;
        cycle();
        iflush = 1'b0;
        cycle();
        mem_ack = 1'b1; mem_rdata = 32'h99999999;
        cycle();
        chk("fl_no_iready", 32'(iready), 32'h0);
        chk("fl_instr_held", instr, 32'h22222222);
        iaddr = 32'h80; mem_ack = 1'b0;
        cycle();
        chk("fl_refetch", mem_addr, 32'h80);
        mem_ack = 1'b1; mem_rdata = 32'h33333333;
        cycle();
        chk("fl_iready", 32'(iready), 32'h1);
        chk("fl_instr", instr, 32'h33333333);
        ireq = 1'b0; mem_ack = 1'b0;
        cycle();

        // reset while a load waits for its ack, then a stray ack
        dreq = 1'b1; dwe = 1'b0; daddr = 32'h104;
        cycle();
        do_reset();
        chk("rst_req", 32'(mem_req), 32'h0);
        dreq = 1'b0; mem_ack = 1'b1;
        cycle();
        chk("stray_dready", 32'(dready), 32'h0);
        chk("stray_iready", 32'(iready), 32'h0);
        mem_ack = 1'b0;

        // fetch held off by a long data access: counter sticks at 15
        ireq = 1'b1; iaddr = 32'h90;
        dreq = 1'b1; dwe = 1'b0; daddr = 32'h300;
        for (int i = 0; i < 20; i++) cycle();
        chk("sat_cnt", 32'(contention_cnt), 32'd15);
        mem_ack = 1'b1;
        cycle();
        chk("sat_hold", 32'(contention_cnt), 32'd15);
        dreq = 1'b0;
        cycle();
        ireq = 1'b0; mem_ack = 1'b0;
        cycle();
        do_reset();

        // randomized traffic with periodic resets
        for (int k = 0; k < 3000; k++) begin
            if (ireq) begin
                if (m_iready) begin
                    ireq  = 1'($urandom_range(0, 1));
                    iaddr = $urandom & 32'hFFFF_FFFC;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                ireq  = 1'b1;
                iaddr = $urandom & 32'hFFFF_FFFC;
            end
            iflush = ($urandom_range(0, 9) == 0);
            if (iflush) iaddr = $urandom & 32'hFFFF_FFFC;

            if (dreq) begin
                if (m_dready) begin
                    dreq   = 1'($urandom_range(0, 1));
                    dwe    = 1'($urandom_range(0, 1));
                    daddr  = $urandom & 32'hFFFF_FFFC;
                    dwdata = $urandom;
                end
            end else if ($urandom_range(0, 3) == 0) begin
                dreq   = 1'b1;
                dwe    = 1'($urandom_range(0, 1));
                daddr  = $urandom & 32'hFFFF_FFFC;
                dwdata = $urandom;
            end

            mem_ack   = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;

            cycle();
            if (k % 500 == 499) do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
